// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that shares one serializer between N_REQ requesters.
// Latches the winner's word and length, issues one ser_dv pulse, and returns done or err.
module serial_tx_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 15,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned TIMEOUT    = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [N_REQ-1:0]              i_req,
    input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_data,
    input  logic [N_REQ*LEN_WIDTH-1:0]    i_req_len,
    output logic [N_REQ-1:0]              o_grant,
    output logic [N_REQ-1:0]              o_done,
    output logic [N_REQ-1:0]              o_err,
    output logic                          o_busy,
    output logic                          o_ser_dv,
    output logic [DATA_WIDTH-1:0]         o_ser_din,
    output logic [LEN_WIDTH-1:0]          o_ser_len,
    input  logic                          i_ser_sent
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAbort} state_e;

    state_e                  r_state;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        r_gidx;
    logic [CNT_W-1:0]        r_cnt;
    logic [N_REQ-1:0]        r_grant;
    logic [N_REQ-1:0]        r_done;
    logic [N_REQ-1:0]        r_err;
    logic                    r_busy;
    logic                    r_dv;
    logic [DATA_WIDTH-1:0]   r_din;
    logic [LEN_WIDTH-1:0]    r_len;

    logic                    w_found;
    logic [IDX_W-1:0]        w_idx;
    logic [IDX_W:0]          w_sum;
    logic [N_REQ-1:0]        w_onehot;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [LEN_WIDTH-1:0]    w_len;

    // Search starts one past the last winner, wrapping modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_sum   = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(N_REQ);
            end
            if (!w_found && i_req[w_sum[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_sum[IDX_W-1:0];
            end
        end
    end

    assign w_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_idx;
    assign w_data   = i_req_data[32'(w_idx) * DATA_WIDTH +: DATA_WIDTH];
    assign w_len    = i_req_len[32'(w_idx) * LEN_WIDTH +: LEN_WIDTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
            r_ptr   <= IDX_W'(N_REQ - 1);
            r_gidx  <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_busy  <= 1'b0;
            r_dv    <= 1'b0;
            r_din   <= '0;
            r_len   <= '0;
        end else begin
            r_dv   <= 1'b0;
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_din   <= w_data;
                        r_len   <= w_len;
                        r_gidx  <= w_idx;
                        r_grant <= w_onehot;
                        r_busy  <= 1'b1;
                        // A zero-length word is rejected without touching the serializer.
                        if (w_len == '0) begin
                            r_err   <= w_onehot;
                            r_ptr   <= w_idx;
                            r_state <= StAbort;
                        end else begin
                            r_dv    <= 1'b1;
                            r_state <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    r_cnt   <= '0;
                    r_state <= StWait;
                end
                StWait: begin
                    if (i_ser_sent) begin
                        r_done  <= r_grant;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_gidx;
                        r_state <= StIdle;
                    end else if (r_cnt == CNT_MAX) begin
                        r_err   <= r_grant;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_gidx;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StAbort: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_grant   = r_grant;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_busy    = r_busy;
    assign o_ser_dv  = r_dv;
    assign o_ser_din = r_din;
    assign o_ser_len = r_len;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: vector table for single transfers, scoreboard for done/err,
// plus hand-written round-robin, spurious-sent and mid-transfer reset sequences.
module tb_serial_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 15;
    localparam int LW = 4;
    localparam int T  = 32;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N*LW-1:0] req_len;
    logic            ser_sent;
    logic [N-1:0]    o_grant, o_done, o_err;
    logic            o_busy, o_ser_dv;
    logic [DW-1:0]   o_ser_din;
    logic [LW-1:0]   o_ser_len;

    int n_vec  = 0;
    int n_miss = 0;
    int n_dv   = 0;
    int exp_dv = 0;

    typedef struct {
        logic [N-1:0] done;
        logic [N-1:0] err;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int           idx;
        logic [DW-1:0] data;
        logic [LW-1:0] len;
        int           d;      // ser_sent sampled d+1 edges after ser_dv is seen; 999 = never
        bit           is_err;
        int           lat;    // edges from ser_dv to done/err
    } vec_t;
    vec_t vecs[8];

    serial_tx_arbiter #(
        .N_REQ(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT(T)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_req(req), .i_req_data(req_data), .i_req_len(req_len),
        .o_grant(o_grant), .o_done(o_done), .o_err(o_err),
        .o_busy(o_busy), .o_ser_dv(o_ser_dv),
        .o_ser_din(o_ser_din), .o_ser_len(o_ser_len),
        .i_ser_sent(ser_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer on the falling edge, away from the active edge.
    always @(negedge clk) begin : mon
        sb_t e;
        if (o_ser_dv) n_dv++;
        if (|o_done || |o_err) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", {o_done, o_err}, '0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_done", o_done, e.done);
                chk("sb_err", o_err, e.err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [DW-1:0] d, input logic [LW-1:0] l);
        req[idx] = 1'b1;
        req_data[idx*DW +: DW] = d;
        req_len[idx*LW +: LW] = l;
    endtask

    task automatic push(input int idx, input bit is_err);
        sb_t e;
        e.done = '0;
        e.err  = '0;
        if (is_err) e.err[idx] = 1'b1;
        else        e.done[idx] = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (o_grant == '0 && cyc < 20);
        if (o_grant == '0) chk("grant_timeout", o_grant, 64'h1);
    endtask

    task automatic finish_xfer(input int d, output int lat);
        int n = 0;
        do begin
            ser_sent = (n == d);
            tick();
            n++;
        end while (!(|o_done || |o_err) && n < 100);
        ser_sent = 1'b0;
        lat = n;
    endtask

    task automatic serve_one(input int exp_idx, input bit drop, output int w);
        int lat;
        wait_grant(w);
        chk("rr_grant", o_grant, 64'(1) << exp_idx);
        if (drop) req[exp_idx] = 1'b0;
        push(exp_idx, 1'b0);
        exp_dv++;
        finish_xfer(2, lat);
        chk("rr_lat", lat, 3);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, lat;
        vecs[0] = '{0, 15'h00A5, 4'd8,  10,  1'b0, 11};
        vecs[1] = '{1, 15'h7FFF, 4'd15, 1,   1'b0, 2};
        vecs[2] = '{3, 15'h1234, 4'd0,  0,   1'b1, 0};
        vecs[3] = '{2, 15'h0F0F, 4'd4,  999, 1'b1, 33};
        vecs[4] = '{3, 15'h5555, 4'd1,  32,  1'b0, 33};
        vecs[5] = '{1, 15'h2AAA, 4'd7,  33,  1'b1, 33};
        vecs[6] = '{0, 15'h0001, 4'd3,  0,   1'b1, 33};
        vecs[7] = '{2, 15'h4000, 4'd15, 31,  1'b0, 32};

        req = '0; req_data = '0; req_len = '0; ser_sent = 1'b0;
        tick();
        tick();
        chk("reset_ctl", {o_grant, o_done, o_err, o_busy, o_ser_dv}, '0);
        chk("reset_data", {o_ser_din, o_ser_len}, '0);
        rstn = 1'b1;
        tick();

        // req[0] and req[2] together straight after reset: 0 first.
        set_req(0, 15'h0111, 4'd5);
        set_req(2, 15'h0222, 4'd6);
        serve_one(0, 1'b1, w);
        serve_one(2, 1'b1, w);
        tick();

        for (int i = 0; i < 8; i++) begin
            set_req(vecs[i].idx, vecs[i].data, vecs[i].len);
            push(vecs[i].idx, vecs[i].is_err);
            if (vecs[i].len != 0) exp_dv++;
            tick();
            chk("v_grant", o_grant, 64'(1) << vecs[i].idx);
            chk("v_dv", o_ser_dv, vecs[i].len != 0);
            chk("v_din", o_ser_din, vecs[i].data);
            chk("v_len", o_ser_len, vecs[i].len);
            chk("v_busy", o_busy, 1);
            // Requester withdraws and scribbles its word; the latched copy must survive.
            req[vecs[i].idx] = 1'b0;
            req_data[vecs[i].idx*DW +: DW] = ~vecs[i].data;
            if (vecs[i].len == 0) begin
                tick();
            end else begin
                finish_xfer(vecs[i].d, lat);
                chk("v_lat", lat, vecs[i].lat);
                chk("v_din_held", o_ser_din, vecs[i].data);
            end
            chk("v_release", {o_grant, o_busy}, '0);
            tick();
        end

        // Two requesters held continuously alternate.
        set_req(0, 15'h0A0A, 4'd3);
        set_req(1, 15'h0B0B, 4'd3);
        serve_one(0, 1'b0, w);
        serve_one(1, 1'b0, w);
        chk("rr_gap", w, 1);
        serve_one(0, 1'b0, w);
        serve_one(1, 1'b0, w);
        req = '0;
        tick();
        tick();

        // Spurious ser_sent while idle.
        ser_sent = 1'b1;
        tick();
        ser_sent = 1'b0;
        chk("spurious_idle", {o_grant, o_done, o_err, o_busy, o_ser_dv}, '0);
        tick();

        // Reset in the middle of a wait, then reset priority restored.
        set_req(2, 15'h0333, 4'd5);
        wait_grant(w);
        exp_dv++;
        tick();
        tick();
        #2 rstn = 1'b0;
        #1;
        chk("async_reset", {o_grant, o_done, o_err, o_busy, o_ser_dv, o_ser_din, o_ser_len}, '0);
        set_req(0, 15'h0444, 4'd6);
        tick();
        rstn = 1'b1;
        serve_one(0, 1'b1, w);
        serve_one(2, 1'b1, w);
        tick();
        tick();

        chk("sb_drained", sb_q.size(), 0);
        chk("dv_count", n_dv, exp_dv);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
